// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: first-word-fall-through, sticky overrun, level and idle-timeout IRQs.
// Define UART_RX_FIFO_TIMEOUT_EN to build in the timeout counter/FSM; otherwise timeout_irq is tied low.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int WATERMARK = 8,
  parameter int TIMEOUT   = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overrun,
  input  logic                     clr_overrun,
  output logic                     level_irq,
  output logic                     timeout_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of 2 in 2..256");
  end
  if (WATERMARK < 1 || WATERMARK > DEPTH) begin : g_bad_wm
    $error("uart_rx_fifo: WATERMARK must be in 1..DEPTH");
  end
  if (TIMEOUT < 2) begin : g_bad_to
    $error("uart_rx_fifo: TIMEOUT must be at least 2");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          wr_en;
  logic          pop;
  logic          ovr_set;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr];

  // A pop frees the slot in the same edge, so a full FIFO still accepts a write alongside it.
  assign pop     = out_valid && out_ready;
  assign wr_en   = in_valid && (!full || pop);
  assign ovr_set = in_valid && full && !pop;

  always_comb begin
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      level_irq <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      // Set beats clear so a drop in the clearing cycle is never lost.
      if (ovr_set)          overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      level_irq <= (count >= CW'(WATERMARK));
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, COUNTING, EXPIRED} to_state_t;

  to_state_t     state;
  to_state_t     state_nxt;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_nxt;

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    case (state)
      IDLE: begin
        if (wr_en) begin
          state_nxt  = COUNTING;
          to_cnt_nxt = '0;
        end
      end
      COUNTING: begin
        if (wr_en || pop)                    to_cnt_nxt = '0;
        else if (to_cnt == TW'(TIMEOUT - 1)) state_nxt  = EXPIRED;
        else                                 to_cnt_nxt = to_cnt + 1'b1;
      end
      EXPIRED: begin
        if (wr_en || pop) begin
          state_nxt  = COUNTING;
          to_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Draining the FIFO overrides everything: nothing left to time out on.
    if (count_nxt == '0) begin
      state_nxt  = IDLE;
      to_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
    end
  end

  assign timeout_irq = (state == EXPIRED);
`else
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, WATERMARK=8, TIMEOUT=1000).
module tb_uart_rx_fifo;

  localparam int DEPTH     = 16;
  localparam int WATERMARK = 8;
  localparam int TIMEOUT   = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overrun;
  logic       clr_overrun;
  logic       level_irq;
  logic       timeout_irq;

  int checks   = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic       do_pop;
  logic       do_push;

  uart_rx_fifo #(.DEPTH(DEPTH), .WATERMARK(WATERMARK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .overrun(overrun), .clr_overrun(clr_overrun),
    .level_irq(level_irq), .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_level_irq", level_irq, 0);
    chk("rst_timeout_irq", timeout_irq, 0);
    tick();
    rst = 1'b0;

    // Basic write/read and fall-through latency
    push(8'hA5);
    chk("fwft_valid", out_valid, 1);
    chk("fwft_data", out_data, 8'hA5);
    push(8'h3C);
    chk("two_count", count, 2);
    chk("two_head", out_data, 8'hA5);
    pop1();
    chk("pop1_data", out_data, 8'h3C);
    chk("pop1_count", count, 1);
    pop1();
    chk("pop2_empty", empty, 1);
    chk("pop2_data", out_data, 8'h00);

    // Empty: simultaneous write and ready performs only the write
    in_data = 8'h77; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("empty_wr_rd_count", count, 1);
    chk("empty_wr_rd_data", out_data, 8'h77);
    pop1();
    chk("empty_again", empty, 1);

    // Overflow: 17 writes into 16 entries
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fill_full", full, 1);
    chk("fill_overrun_clear", overrun, 0);
    push(8'h10);
    chk("ovf_overrun", overrun, 1);
    chk("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", out_data, 8'(i));
      pop1();
    end
    chk("ovf_drained_empty", empty, 1);
    chk("ovf_still_sticky", overrun, 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("clr_overrun", overrun, 0);

    // Full with simultaneous pop and write; then set-vs-clear priority
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    in_data = 8'hEE; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("full_rw_count", count, 16);
    chk("full_rw_overrun", overrun, 0);
    chk("full_rw_head", out_data, 8'h21);
    in_data = 8'hFF; in_valid = 1'b1; clr_overrun = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("set_wins", overrun, 1);
    tick();
    clr_overrun = 1'b0;
    chk("clr_after_set", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      chk("full_rw_drain", out_data, (i == 15) ? 8'hEE : 8'(8'h21 + i));
      pop1();
    end
    chk("full_rw_empty", empty, 1);

    // Watermark interrupt timing
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    chk("wm_count", count, 8);
    chk("wm_irq_not_yet", level_irq, 0);
    tick();
    chk("wm_irq_set", level_irq, 1);
    pop1();
    chk("wm_irq_held", level_irq, 1);
    tick();
    chk("wm_irq_clear", level_irq, 0);
    for (int i = 0; i < 7; i++) pop1();
    chk("wm_drained", empty, 1);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    push(8'h42);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("to_before", timeout_irq, 0);
    tick();
    chk("to_expired", timeout_irq, 1);
    pop1();
    chk("to_cleared", timeout_irq, 0);
    chk("to_empty", empty, 1);
`else
    push(8'h42);
    for (int i = 0; i < 20; i++) tick();
    chk("to_tied_low", timeout_irq, 0);
    pop1();
    chk("to_empty", empty, 1);
`endif

    // Interleaved stream across pointer wraps, tracked by a queue model
    for (int i = 0; i < 40; i++) begin
      in_data   = 8'(8'h80 + i);
      in_valid  = 1'b1;
      out_ready = (i % 3 != 0);
      chk("sb_count", count, q.size());
      if (q.size() > 0) chk("sb_head", out_data, q[0]);
      do_pop  = out_ready && (q.size() > 0);
      do_push = (q.size() < DEPTH) || do_pop;
      tick();
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(8'(8'h80 + i));
    end
    chk("sb_final_count", count, q.size());

    // Asynchronous reset mid-stream
    in_data = 8'h99; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 8'h00);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    push(8'h5A);
    chk("post_rst_head", out_data, 8'h5A);
    chk("post_rst_count", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
